pc_fetch_sequencer: RTL and testbench

- Multicycle fetch/update controller for the MIPS program counter register.
- Drives the PC register's enable and next-value input, and issues request/acknowledge instruction-memory fetches at the current PC.
- Holds the fetched instruction for the execute stage and selects the next PC from five sources: sequential, branch, jump, register jump and exception vector.
- Sits between the PC register, the instruction memory and the core control unit.

---
 rtl/mips_pc_pkg.sv | 37 +++
 rtl/pc_fetch_sequencer_if.sv | 26 ++
 rtl/pc_target_calc.sv | 43 ++++
 rtl/pc_fetch_sequencer.sv | 112 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pc_pkg.sv
// Shared constants for the MIPS PC fetch/update sequencer: FSM encoding,
// next-PC source encoding and instruction field positions.
package mips_pc_pkg;

  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  localparam int PC_INC = 4;

  localparam logic [2:0] SEL_SEQ = 3'd0;
  localparam logic [2:0] SEL_BR  = 3'd1;
  localparam logic [2:0] SEL_J   = 3'd2;
  localparam logic [2:0] SEL_JR  = 3'd3;
  localparam logic [2:0] SEL_EXC = 3'd4;

  localparam int IMM_MSB         = 15;
  localparam int JUMP_IDX_MSB    = 25;
  localparam int JUMP_REGION_LSB = 28;

  // Exceptions win over every redirect, register jumps over direct jumps,
  // and any jump over a taken branch.
  function automatic logic [2:0] next_pc_select(input logic exc_req,
                                                input logic jump_reg,
                                                input logic jump,
                                                input logic branch_taken);
    logic [2:0] sel;
    sel = SEL_SEQ;
    if (exc_req)           sel = SEL_EXC;
    else if (jump_reg)     sel = SEL_JR;
    else if (jump)         sel = SEL_J;
    else if (branch_taken) sel = SEL_BR;
    return sel;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Request/acknowledge instruction-memory fetch bus between the sequencer
// (master) and the instruction memory (slave).
interface pc_fetch_sequencer_if #(
  parameter int WORD_LENGTH = 32
);

  logic                   imem_req;
  logic [WORD_LENGTH-1:0] imem_addr;
  logic                   imem_ack;
  logic [WORD_LENGTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC target generator: sequential, branch, jump,
// register jump and exception vector, chosen by an encoded select.
module pc_target_calc
  import mips_pc_pkg::*;
#(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] EXC_VECTOR  = 'h8000_0180
) (
  input  logic [WORD_LENGTH-1:0]  pc_current,
  input  logic [JUMP_IDX_MSB:0]   instr_out,
  input  logic [WORD_LENGTH-1:0]  jr_target,
  input  logic [2:0]              select,
  output logic [WORD_LENGTH-1:0]  target
);

  logic [WORD_LENGTH-1:0] pc_plus4;
  logic [WORD_LENGTH-1:0] branch_offset;
  logic [WORD_LENGTH-1:0] jump_target;
  logic [WORD_LENGTH-1:0] jr_aligned;

  assign pc_plus4 = pc_current + WORD_LENGTH'(PC_INC);

  // Word offset: sign-extended 16-bit immediate scaled by 4.
  assign branch_offset = {{(WORD_LENGTH-IMM_MSB-3){instr_out[IMM_MSB]}},
                          instr_out[IMM_MSB:0], 2'b00};

  assign jump_target = {pc_plus4[WORD_LENGTH-1:JUMP_REGION_LSB],
                        instr_out[JUMP_IDX_MSB:0], 2'b00};

  assign jr_aligned = jr_target & ~WORD_LENGTH'(3);

  always_comb begin
    target = pc_plus4;
    case (select)
      SEL_EXC: target = EXC_VECTOR;
      SEL_JR:  target = jr_aligned;
      SEL_J:   target = jump_target;
      SEL_BR:  target = pc_plus4 + branch_offset;
      default: target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multicycle MIPS fetch/update controller: boots, fetches at the current PC,
// holds the instruction for execute, then loads the selected next PC.
module pc_fetch_sequencer
  import mips_pc_pkg::*;
#(
  parameter int                     WORD_LENGTH       = 32,
  parameter logic [WORD_LENGTH-1:0] DATA_BASE_ADDRESS = 'h40_0000,
  parameter logic [WORD_LENGTH-1:0] EXC_VECTOR        = 'h8000_0180
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] pc_current,
  output logic                   pc_enable,
  output logic [WORD_LENGTH-1:0] pc_next,
  input  logic                   stall,
  pc_fetch_sequencer_if.master   imem,
  output logic                   instr_valid,
  output logic [WORD_LENGTH-1:0] instr_out,
  input  logic                   exec_done,
  input  logic                   branch_taken,
  input  logic                   jump,
  input  logic                   jump_reg,
  input  logic [WORD_LENGTH-1:0] jr_target,
  input  logic                   exc_req,
  output logic [WORD_LENGTH-1:0] epc,
  output logic [31:0]            retired_count
);

  logic [1:0]             state_q, state_d;
  logic [WORD_LENGTH-1:0] instr_q, instr_d;
  logic [WORD_LENGTH-1:0] pc_next_q, pc_next_d;
  logic [WORD_LENGTH-1:0] epc_q, epc_d;
  logic [31:0]            retired_count_q, retired_count_d;

  logic                   fetch_req;
  logic [2:0]             target_sel;
  logic [WORD_LENGTH-1:0] target;

  assign fetch_req  = (state_q == S_FETCH) && !stall;
  assign target_sel = next_pc_select(exc_req, jump_reg, jump, branch_taken);

  pc_target_calc #(
    .WORD_LENGTH (WORD_LENGTH),
    .EXC_VECTOR  (EXC_VECTOR)
  ) u_target_calc (
    .pc_current (pc_current),
    .instr_out  (instr_q[JUMP_IDX_MSB:0]),
    .jr_target  (jr_target),
    .select     (target_sel),
    .target     (target)
  );

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    pc_next_d       = pc_next_q;
    epc_d           = epc_q;
    retired_count_d = retired_count_q;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (fetch_req && imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Redirect inputs are only meaningful in the exec_done cycle.
        if (exec_done) begin
          pc_next_d = target;
          if (exc_req) epc_d = pc_current;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        retired_count_d = retired_count_q + 32'd1;
        state_d         = S_FETCH;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_BOOT;
      instr_q         <= '0;
      pc_next_q       <= '0;
      epc_q           <= '0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      pc_next_q       <= pc_next_d;
      epc_q           <= epc_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign imem.imem_req  = fetch_req;
  assign imem.imem_addr = (state_q == S_FETCH) ? pc_current : '0;
  assign instr_valid    = (state_q == S_EXEC);
  assign pc_enable      = (state_q == S_UPDATE);
  assign instr_out      = instr_q;
  assign pc_next        = pc_next_q;
  assign epc            = epc_q;
  assign retired_count  = retired_count_q;

  // The PC register must have settled to its reset value by the boot cycle.
  boot_pc_check: assert property (@(posedge clk) disable iff (!reset)
    (state_q == S_BOOT) |-> (pc_current == DATA_BASE_ADDRESS));

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus a
// randomized instruction stream checked against an architectural next-PC model.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] EXC  = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_current, pc_next, instr_out, jr_target, epc, retired_count;
  logic        pc_enable, stall, instr_valid, exec_done;
  logic        branch_taken, jump, jump_reg, exc_req;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_pc_next, model_epc, model_count;

  pc_fetch_sequencer_if #(.WORD_LENGTH(32)) imem_bus ();

  pc_fetch_sequencer #(
    .WORD_LENGTH       (32),
    .DATA_BASE_ADDRESS (BASE),
    .EXC_VECTOR        (EXC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_current    (pc_current),
    .pc_enable     (pc_enable),
    .pc_next       (pc_next),
    .stall         (stall),
    .imem          (imem_bus),
    .instr_valid   (instr_valid),
    .instr_out     (instr_out),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .jump_reg      (jump_reg),
    .jr_target     (jr_target),
    .exc_req       (exc_req),
    .epc           (epc),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  // Architectural next-PC rule, written straight from the MIPS definitions.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                             input logic [31:0] jrt, input logic exc,
                                             input logic jr, input logic j, input logic br);
    logic [31:0] seq;
    int imm;
    seq = pc + 32'd4;
    imm = int'($signed(instr[15:0]));
    if (exc) return EXC;
    if (jr)  return jrt & 32'hFFFF_FFFC;
    if (j)   return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    if (br)  return seq + 32'(imm * 4);
    return seq;
  endfunction

  task automatic model_retire(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] jrt, input logic exc,
                              input logic jr, input logic j, input logic br);
    model_pc_next = model_next(pc, instr, jrt, exc, jr, j, br);
    if (exc) model_epc = pc;
    model_count = model_count + 32'd1;
  endtask

  // Drives one full fetch/exec/update transaction starting from a FETCH-state negedge.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] instr,
                           input logic exc, input logic jr, input logic j, input logic br,
                           input logic [31:0] jrt, input int ack_wait, input int exec_wait,
                           output logic [31:0] got_instr, output logic [31:0] got_next,
                           output logic [31:0] got_epc, output logic [31:0] got_count,
                           output int pulses, output bit timed_out);
    int n;
    pulses = 0;
    timed_out = 1'b0;
    pc_current = pc;
    imem_bus.imem_rdata = instr;
    imem_bus.imem_ack = 1'b0;
    stall = 1'b0;
    repeat (ack_wait) begin
      @(negedge clk);
      pulses += int'(pc_enable);
    end
    imem_bus.imem_ack = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      pulses += int'(pc_enable);
      n++;
    end while (instr_valid !== 1'b1 && n < 20);
    if (instr_valid !== 1'b1) timed_out = 1'b1;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = $urandom;
    got_instr = instr_out;
    repeat (exec_wait) begin
      {exc_req, jump_reg, jump, branch_taken} = 4'($urandom);
      jr_target = $urandom;
      @(negedge clk);
      pulses += int'(pc_enable);
    end
    {exc_req, jump_reg, jump, branch_taken} = {exc, jr, j, br};
    jr_target = jrt;
    exec_done = 1'b1;
    @(negedge clk);
    pulses += int'(pc_enable);
    exec_done = 1'b0;
    {exc_req, jump_reg, jump, branch_taken} = 4'b0;
    @(negedge clk);
    pulses += int'(pc_enable);
    got_next  = pc_next;
    got_epc   = epc;
    got_count = retired_count;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pc_current = BASE;
    stall = 1'b0;
    exec_done = 1'b0;
    {exc_req, jump_reg, jump, branch_taken} = 4'b0;
    jr_target = '0;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = 32'h1234_5678;
    model_pc_next = '0;
    model_epc = '0;
    model_count = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pc_enable, imem_bus.imem_req, instr_valid, imem_bus.imem_addr, instr_out,
         pc_next, epc, retired_count} !== '0) begin
      $display("[TB] FAIL reset_outputs got en=%b req=%b valid=%b addr=%h instr=%h next=%h epc=%h cnt=%h required all zero",
               pc_enable, imem_bus.imem_req, instr_valid, imem_bus.imem_addr, instr_out,
               pc_next, epc, retired_count);
      failures++;
    end
  endtask

  task automatic test_boot();
    logic [31:0] gi, gn, ge, gc;
    int p;
    bit to;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      $display("[TB] FAIL boot_cycle_req got=%b required=0", imem_bus.imem_req);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== BASE) begin
      $display("[TB] FAIL boot_fetch got req=%b addr=%h required req=1 addr=%h",
               imem_bus.imem_req, imem_bus.imem_addr, BASE);
      failures++;
    end
    run_instr(BASE, 32'h2002_0005, 0, 0, 0, 0, '0, 0, 0, gi, gn, ge, gc, p, to);
    model_retire(BASE, 32'h2002_0005, '0, 0, 0, 0, 0);
    checks++;
    if (to || gi !== 32'h2002_0005) begin
      $display("[TB] FAIL boot_instr got=%h timeout=%0d required=20020005", gi, to);
      failures++;
    end
    checks++;
    if (gn !== 32'h0040_0004 || gn !== model_pc_next) begin
      $display("[TB] FAIL boot_pc_next got=%h required=%h", gn, model_pc_next);
      failures++;
    end
    checks++;
    if (p != 1 || gc !== model_count) begin
      $display("[TB] FAIL boot_update got pulses=%0d count=%h required pulses=1 count=%h",
               p, gc, model_count);
      failures++;
    end
  endtask

  task automatic test_branch();
    logic [31:0] gi, gn, ge, gc, instr;
    int p;
    bit to;
    instr = {16'($urandom), 16'hFFFE};
    run_instr(32'h0040_0010, instr, 0, 0, 0, 1, '0, 0, 1, gi, gn, ge, gc, p, to);
    model_retire(32'h0040_0010, instr, '0, 0, 0, 0, 1);
    checks++;
    if (to || gn !== 32'h0040_000C || gn !== model_pc_next) begin
      $display("[TB] FAIL branch_back got=%h required=%h timeout=%0d", gn, model_pc_next, to);
      failures++;
    end
    instr = $urandom;
    instr[15:0] = 16'hFFFE;
    run_instr(32'h0040_0010, instr, 0, 0, 1, 1, '0, 0, 0, gi, gn, ge, gc, p, to);
    model_retire(32'h0040_0010, instr, '0, 0, 0, 1, 1);
    checks++;
    if (to || gn !== model_pc_next) begin
      $display("[TB] FAIL jump_over_branch got=%h required=%h", gn, model_pc_next);
      failures++;
    end
  endtask

  task automatic test_exception();
    logic [31:0] gi, gn, ge, gc, instr;
    int p;
    bit to;
    instr = $urandom;
    run_instr(32'h0040_0020, instr, 1, 1, 1, 0, 32'h0040_0103, 1, 2, gi, gn, ge, gc, p, to);
    model_retire(32'h0040_0020, instr, 32'h0040_0103, 1, 1, 1, 0);
    checks++;
    if (to || gn !== EXC || ge !== 32'h0040_0020) begin
      $display("[TB] FAIL exc_priority got next=%h epc=%h required next=%h epc=00400020",
               gn, ge, EXC);
      failures++;
    end
    checks++;
    if (p != 1 || gc !== model_count) begin
      $display("[TB] FAIL exc_retire got pulses=%0d count=%h required pulses=1 count=%h",
               p, gc, model_count);
      failures++;
    end
    run_instr(32'h0040_0020, instr, 0, 1, 0, 0, 32'h0040_0103, 0, 0, gi, gn, ge, gc, p, to);
    model_retire(32'h0040_0020, instr, 32'h0040_0103, 0, 1, 0, 0);
    checks++;
    if (to || gn !== 32'h0040_0100 || ge !== model_epc) begin
      $display("[TB] FAIL jump_reg got next=%h epc=%h required next=00400100 epc=%h",
               gn, ge, model_epc);
      failures++;
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    pc_current = 32'h0040_0040;
    stall = 1'b1;
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    repeat (5) begin
      @(negedge clk);
      if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_enable !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("[TB] FAIL stall_hold got %0d bad cycles required 0", bad);
      failures++;
    end
    stall = 1'b0;
    imem_bus.imem_rdata = 32'h0123_4567;
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b1) begin
      $display("[TB] FAIL stall_release_req got=%b required=1", imem_bus.imem_req);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== 32'h0123_4567) begin
      $display("[TB] FAIL stall_fetch got valid=%b instr=%h required valid=1 instr=01234567",
               instr_valid, instr_out);
      failures++;
    end
    imem_bus.imem_ack = 1'b0;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    @(negedge clk);
    model_retire(32'h0040_0040, 32'h0123_4567, '0, 0, 0, 0, 0);
    checks++;
    if (pc_next !== model_pc_next || retired_count !== model_count) begin
      $display("[TB] FAIL stall_update got next=%h cnt=%h required next=%h cnt=%h",
               pc_next, retired_count, model_pc_next, model_count);
      failures++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] gi, gn, ge, gc, instr;
    int p;
    bit to;
    force dut.retired_count_q = 32'hFFFF_FFFF;
    #1 release dut.retired_count_q;
    model_count = 32'hFFFF_FFFF;
    instr = $urandom;
    run_instr(32'hFFFF_FFFC, instr, 0, 0, 0, 0, '0, 0, 0, gi, gn, ge, gc, p, to);
    model_retire(32'hFFFF_FFFC, instr, '0, 0, 0, 0, 0);
    checks++;
    if (to || gn !== 32'h0) begin
      $display("[TB] FAIL pc_wrap got=%h required=00000000", gn);
      failures++;
    end
    checks++;
    if (gc !== 32'h0 || gc !== model_count) begin
      $display("[TB] FAIL count_wrap got=%h required=00000000", gc);
      failures++;
    end
  endtask

  task automatic test_random();
    logic [31:0] gi, gn, ge, gc, pc, instr, jrt;
    logic [3:0] f;
    int p;
    bit to;
    int bad = 0;
    for (int i = 0; i < 24; i++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      instr = $urandom;
      jrt = $urandom;
      f = 4'($urandom);
      run_instr(pc, instr, f[3], f[2], f[1], f[0], jrt, $urandom_range(0, 3),
                $urandom_range(0, 3), gi, gn, ge, gc, p, to);
      model_retire(pc, instr, jrt, f[3], f[2], f[1], f[0]);
      checks++;
      if (to || gi !== instr || gn !== model_pc_next || ge !== model_epc ||
          gc !== model_count || p != 1) begin
        $display("[TB] FAIL random_%0d got instr=%h next=%h epc=%h cnt=%h pulses=%0d required instr=%h next=%h epc=%h cnt=%h pulses=1",
                 i, gi, gn, ge, gc, p, instr, model_pc_next, model_epc, model_count);
        failures++;
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] gi, gn, ge, gc;
    int p;
    bit to;
    pc_current = 32'h0040_0050;
    imem_bus.imem_rdata = $urandom | 32'h1;
    imem_bus.imem_ack = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1) begin
      $display("[TB] FAIL mid_exec_entry got valid=%b required=1", instr_valid);
      failures++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({pc_enable, imem_bus.imem_req, instr_valid, imem_bus.imem_addr, instr_out,
         pc_next, epc, retired_count} !== '0) begin
      $display("[TB] FAIL async_reset got en=%b req=%b valid=%b instr=%h next=%h epc=%h cnt=%h required all zero",
               pc_enable, imem_bus.imem_req, instr_valid, instr_out, pc_next, epc, retired_count);
      failures++;
    end
    pc_current = BASE;
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_out !== '0 || imem_bus.imem_req !== 1'b0 || pc_enable !== 1'b0) begin
      $display("[TB] FAIL ack_in_reset got instr=%h req=%b en=%b required 0", instr_out,
               imem_bus.imem_req, pc_enable);
      failures++;
    end
    model_pc_next = '0;
    model_epc = '0;
    model_count = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    imem_bus.imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      $display("[TB] FAIL reboot_cycle_req got=%b required=0", imem_bus.imem_req);
      failures++;
    end
    @(negedge clk);
    run_instr(BASE, 32'h0000_0020, 0, 0, 0, 0, '0, 0, 0, gi, gn, ge, gc, p, to);
    model_retire(BASE, 32'h0000_0020, '0, 0, 0, 0, 0);
    checks++;
    if (to || gn !== model_pc_next || gc !== 32'd1 || p != 1) begin
      $display("[TB] FAIL reboot_first got next=%h cnt=%h pulses=%0d required next=%h cnt=1 pulses=1",
               gn, gc, p, model_pc_next);
      failures++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_boot();
    test_branch();
    test_exception();
    test_stall();
    test_wrap();
    test_random();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
